// File: rtl/bist_pkg.sv
// Shared types and default constants for the LFSR BIST controller.
// The default constants are sized for WIDTH=4.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_SIGN,
    ST_DONE
  } bist_state_t;

  localparam logic [3:0] DEF_SEED      = 4'b0001;
  localparam logic [3:0] DEF_MISR_TAPS = 4'b0011;
  localparam logic [3:0] DEF_GOLDEN    = 4'b0000;

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register that folds each CUT response into a running signature.
module misr_compactor
  import bist_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = DEF_MISR_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_next;

  assign sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? TAPS : '0) ^ resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/lfsr_bist_controller.sv
// BIST sequencer: seeds and steps an external LFSR, compacts the CUT response into a MISR.
// Define BIST_GOLDEN_CMP_EN to compare the final signature against GOLDEN on chip.
module lfsr_bist_controller
  import bist_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               PATTERN_COUNT = 15,
  parameter logic [WIDTH-1:0] SEED          = DEF_SEED,
  parameter logic [WIDTH-1:0] MISR_TAPS     = DEF_MISR_TAPS,
  parameter logic [WIDTH-1:0] GOLDEN        = DEF_GOLDEN
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [WIDTH-1:0]                       resp,
  output logic                                   lfsr_load,
  output logic [WIDTH-1:0]                       lfsr_seed,
  output logic                                   lfsr_en,
  output logic                                   busy,
  output logic                                   done,
  output logic [WIDTH-1:0]                       signature,
  output logic                                   pass,
  output logic [$clog2(PATTERN_COUNT+1)-1:0]     pat_cnt
);

  localparam int               CNT_W    = $clog2(PATTERN_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PATTERN_COUNT);

  bist_state_t state, state_next;
  logic        misr_clr;
  logic        misr_en;

  assign lfsr_seed = SEED;

  // An abort freezes the MISR and counter on the same edge that returns to IDLE.
  assign misr_clr = (state == ST_SEED) && !abort;
  assign misr_en  = (state == ST_RUN)  && !abort;

  misr_compactor #(
    .WIDTH (WIDTH),
    .TAPS  (MISR_TAPS)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .clr  (misr_clr),
    .en   (misr_en),
    .resp (resp),
    .sig  (signature)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_SEED;
      ST_SEED: state_next = ST_RUN;
      ST_RUN:  if (pat_cnt == CNT_LAST) state_next = ST_SIGN;
      ST_SIGN: state_next = ST_DONE;
      ST_DONE: if (start) state_next = ST_SEED;
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_load <= 1'b0;
      lfsr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      lfsr_load <= (state_next == ST_SEED);
      lfsr_en   <= (state_next == ST_RUN);
      busy      <= (state_next == ST_SEED) || (state_next == ST_RUN) ||
                   (state_next == ST_SIGN);
      done      <= (state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_cnt <= '0;
    end else if (!abort) begin
      if (state == ST_SEED) begin
        pat_cnt <= '0;
      end else if ((state == ST_RUN) && (pat_cnt != CNT_MAX)) begin
        pat_cnt <= pat_cnt + 1'b1;
      end
    end
  end

`ifdef BIST_GOLDEN_CMP_EN
  // The MISR is already frozen in SIGN, so the compare sees the final signature.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass <= 1'b0;
    end else if (abort || (state == ST_SEED)) begin
      pass <= 1'b0;
    end else if (state == ST_SIGN) begin
      pass <= (signature == GOLDEN);
    end
  end
`else
  logic golden_unused;

  assign golden_unused = ^GOLDEN;
  assign pass          = 1'b0;
`endif

endmodule
